// File: rtl/imem_dmem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and data access.
// MEM wins collisions; a saturating starvation counter hands IF one slot after STARVE_MAX denials.
module imem_dmem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_mem,
  output logic [1:0]    dbg_resp_owner,
  output logic [3:0]    dbg_starve_cnt
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DRD  = 2'd2,
    OWN_DWR  = 2'd3
  } owner_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  owner_e        resp_owner_q, resp_owner_d;
  logic [3:0]    starve_cnt_q, starve_cnt_d;
  logic [DW-1:0] if_hold_q, d_hold_q;
  logic          gnt_if, gnt_d, starved;

  // Handshake: a request is held stable while its stall is high; the cycle it is
  // granted (stall low) it is consumed, and its response pulses valid exactly one cycle later.
  always_comb begin
    starved = (starve_cnt_q == STARVE_LIM);
    gnt_if  = if_req & (~d_req | starved);
    gnt_d   = d_req & ~gnt_if;
  end

  always_comb begin
    mem_en    = gnt_if | gnt_d;
    mem_we    = gnt_d & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_d) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (gnt_if) begin
      mem_addr  = if_addr;
    end
    stall_if  = if_req & ~gnt_if;
    stall_mem = d_req & ~gnt_d;
  end

  always_comb begin
    resp_owner_d = OWN_NONE;
    if (gnt_if)             resp_owner_d = OWN_IF;
    else if (gnt_d && d_we) resp_owner_d = OWN_DWR;
    else if (gnt_d)         resp_owner_d = OWN_DRD;

    starve_cnt_d = starve_cnt_q;
    if (!if_req || gnt_if)         starve_cnt_d = '0;
    else if (starve_cnt_q < STARVE_LIM) starve_cnt_d = starve_cnt_q + 4'd1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      resp_owner_q <= OWN_NONE;
      starve_cnt_q <= '0;
      if_hold_q    <= '0;
      d_hold_q     <= '0;
    end else begin
      resp_owner_q <= resp_owner_d;
      starve_cnt_q <= starve_cnt_d;
      if (resp_owner_q == OWN_IF)  if_hold_q <= mem_rdata;
      if (resp_owner_q == OWN_DRD) d_hold_q  <= mem_rdata;
    end
  end

  // Store acks pulse d_valid but leave the last load value on d_rdata.
  always_comb begin
    if_valid       = (resp_owner_q == OWN_IF);
    d_valid        = (resp_owner_q == OWN_DRD) || (resp_owner_q == OWN_DWR);
    if_rdata       = if_valid ? mem_rdata : if_hold_q;
    d_rdata        = (resp_owner_q == OWN_DRD) ? mem_rdata : d_hold_q;
    dbg_resp_owner = resp_owner_q;
    dbg_starve_cnt = starve_cnt_q;
  end

endmodule
